// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC multi-cycle controller: opcodes, ALU codes and FSM states.
package sisc_pkg;

  typedef enum logic [2:0] {
    StStart,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ALU_REG = 4'h1;
  localparam logic [3:0] OP_ALU_IMM = 4'h2;
  localparam logic [3:0] OP_LOAD    = 4'h3;
  localparam logic [3:0] OP_STORE   = 4'h4;
  localparam logic [3:0] OP_BRA     = 4'h5;
  localparam logic [3:0] OP_BNE     = 4'h6;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'h1;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_BNE) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/sisc_mc_ctrl_if.sv
// Decoder inputs, memory handshakes and datapath strobes of the SISC controller.
interface sisc_mc_ctrl_if #(
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned STAT_W = 4
);
  logic [OPC_W-1:0]  opcode;
  logic [STAT_W-1:0] mm;
  logic [STAT_W-1:0] stat;
  logic              imem_ack;
  logic              dmem_ack;

  logic              imem_req;
  logic              ir_load;
  logic              pc_write;
  logic              pc_sel;
  logic              rf_we;
  logic              wb_sel;
  logic [3:0]        alu_op;
  logic              alu_imm;
  logic              stat_en;
  logic              dmem_req;
  logic              dmem_we;
  logic              halted;
  logic [1:0]        err;

  modport master (
    input  opcode, mm, stat, imem_ack, dmem_ack,
    output imem_req, ir_load, pc_write, pc_sel, rf_we, wb_sel, alu_op, alu_imm, stat_en,
           dmem_req, dmem_we, halted, err
  );

  modport slave (
    output opcode, mm, stat, imem_ack, dmem_ack,
    input  imem_req, ir_load, pc_write, pc_sel, rf_we, wb_sel, alu_op, alu_imm, stat_en,
           dmem_req, dmem_we, halted, err
  );

endinterface

// File: rtl/sisc_wait_cnt.sv
// Memory-ack wait counter; o_expire flags the cycle in which the count would reach TIMEOUT.
module sisc_wait_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_f,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CntMax)) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  // An ack in the final wait cycle drops i_inc, so it beats the timeout.
  assign o_expire = i_inc && (r_cnt == CntLast);

endmodule

// File: rtl/sisc_mc_ctrl.sv
// Multi-cycle SISC control FSM: fetch/decode/execute/memory/write-back with ack timeouts.
module sisc_mc_ctrl
  import sisc_pkg::*;
#(
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned STAT_W  = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  sisc_mc_ctrl_if.master    io_bus
);

  state_e     r_state;
  state_e     w_state_d;
  logic [1:0] r_err;
  logic [1:0] w_err_d;

  logic [3:0] w_opc;
  logic       w_br_hit;
  logic       w_inc;
  logic       w_clr;
  logic       w_expire;

  logic       w_imem_req;
  logic       w_ir_load;
  logic       w_pc_write;
  logic       w_pc_sel;
  logic       w_rf_we;
  logic       w_wb_sel;
  logic [3:0] w_alu_op;
  logic       w_alu_imm;
  logic       w_stat_en;
  logic       w_dmem_req;
  logic       w_dmem_we;

  assign w_opc    = 4'(io_bus.opcode);
  assign w_br_hit = |(io_bus.stat & io_bus.mm);

  assign w_inc = ((r_state == StFetch) && !io_bus.imem_ack) ||
                 ((r_state == StMem)   && !io_bus.dmem_ack);
  assign w_clr = (w_state_d != r_state) && ((w_state_d == StFetch) || (w_state_d == StMem));

  sisc_wait_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_f    (rst_f),
    .i_clr    (w_clr),
    .i_inc    (w_inc),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state <= StStart;
      r_err   <= '0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_err_d    = r_err;
    w_imem_req = 1'b0;
    w_ir_load  = 1'b0;
    w_pc_write = 1'b0;
    w_pc_sel   = 1'b0;
    w_rf_we    = 1'b0;
    w_wb_sel   = 1'b0;
    w_alu_op   = 4'h0;
    w_alu_imm  = 1'b0;
    w_stat_en  = 1'b0;
    w_dmem_req = 1'b0;
    w_dmem_we  = 1'b0;

    unique case (r_state)
      StStart: w_state_d = StFetch;

      StFetch: begin
        w_imem_req = 1'b1;
        if (io_bus.imem_ack) begin
          w_ir_load  = 1'b1;
          w_pc_write = 1'b1;
          w_state_d  = StDecode;
        end else if (w_expire) begin
          w_err_d[1] = 1'b1;
          w_state_d  = StHalt;
        end
      end

      StDecode: w_state_d = (w_opc == OP_HALT) ? StHalt : StExec;

      StExec: begin
        w_state_d = StFetch;
        if (w_opc == OP_ALU_REG || w_opc == OP_ALU_IMM) begin
          w_alu_op  = 4'(io_bus.mm);
          w_alu_imm = (w_opc == OP_ALU_IMM);
          w_stat_en = 1'b1;
          w_state_d = StWb;
        end else if (w_opc == OP_LOAD || w_opc == OP_STORE) begin
          w_alu_op  = ALU_ADD;
          w_alu_imm = 1'b1;
          w_state_d = StMem;
        end else if (w_opc == OP_BRA || w_opc == OP_BNE) begin
          w_pc_write = (w_opc == OP_BRA) ? w_br_hit : !w_br_hit;
          w_pc_sel   = w_pc_write;
        end else if (!op_is_legal(w_opc)) begin
          w_err_d[0] = 1'b1;
        end
      end

      StMem: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (w_opc == OP_STORE);
        if (io_bus.dmem_ack) begin
          w_state_d = (w_opc == OP_STORE) ? StFetch : StWb;
        end else if (w_expire) begin
          w_err_d[1] = 1'b1;
          w_state_d  = StHalt;
        end
      end

      StWb: begin
        w_rf_we   = 1'b1;
        w_wb_sel  = (w_opc == OP_LOAD);
        w_state_d = StFetch;
      end

      StHalt: w_state_d = StHalt;

      default: w_state_d = StHalt;
    endcase
  end

  assign io_bus.imem_req = w_imem_req;
  assign io_bus.ir_load  = w_ir_load;
  assign io_bus.pc_write = w_pc_write;
  assign io_bus.pc_sel   = w_pc_sel;
  assign io_bus.rf_we    = w_rf_we;
  assign io_bus.wb_sel   = w_wb_sel;
  assign io_bus.alu_op   = w_alu_op;
  assign io_bus.alu_imm  = w_alu_imm;
  assign io_bus.stat_en  = w_stat_en;
  assign io_bus.dmem_req = w_dmem_req;
  assign io_bus.dmem_we  = w_dmem_we;
  assign io_bus.halted   = (r_state == StHalt);
  assign io_bus.err      = r_err;

endmodule
